// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with halt parking, illegal-opcode trap and retire counter
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  input  logic             halt,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB,
    BRANCH, ADDIEX, ADDIWB, JUMP, ILLEGAL
  } state_t;
  state_t state_q, state_d;
  logic sw_q, sw_d;
  logic retire;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      sw_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    retire      = 1'b0;
    state_d     = state_q;
    sw_d        = sw_q;
    if (rst) begin
      case (state_q)
        FETCH: if (!halt) begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          state_d = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          sw_d    = opcode == 6'b101011;
          state_d = (opcode == 6'b100011 || opcode == 6'b101011) ? MEMADR :
                    opcode == 6'b000000 ? EXEC :
                    opcode == 6'b000100 ? BRANCH :
                    opcode == 6'b001000 ? ADDIEX :
                    opcode == 6'b000010 ? JUMP : ILLEGAL;
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = sw_q ? MEMWR : MEMRD;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          state_d = mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
          retire   = 1'b1;
          state_d  = FETCH;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          retire   = mem_ready;
          state_d  = mem_ready ? FETCH : MEMWR;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          state_d = ALUWB;
        end
        ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
          retire   = 1'b1;
          state_d  = FETCH;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          retire      = 1'b1;
          state_d     = FETCH;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = ADDIWB;
        end
        ADDIWB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
          state_d  = FETCH;
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          retire   = 1'b1;
          state_d  = FETCH;
        end
        ILLEGAL: state_d = ILLEGAL;
        default: state_d = FETCH;
      endcase
    end
    cnt_d = (retire && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  assign state       = state_q;
  assign busy        = rst && state_q != FETCH;
  assign illegal     = rst && state_q == ILLEGAL;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
  logic clk, rst, mem_ready, halt;
  logic [5:0] opcode;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic busy, illegal;
  logic [2:0] instr_count;
  logic [15:0] strobes;
  int checks = 0;
  int failures = 0;
  mips_multicycle_ctrl #(.CNT_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .halt(halt),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .busy(busy), .illegal(illegal),
    .instr_count(instr_count)
  );
  assign strobes = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                    RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic cyc(input string tag, input logic [3:0] s, input logic [15:0] st);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".strobes"}, 32'(strobes), 32'(st));
    step();
  endtask
  initial begin
    rst = 1; mem_ready = 1; halt = 0; opcode = 6'b000000;
    #3 rst = 0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst.strobes", 32'(strobes), 32'h0);
    chk("rst.state", 32'(state), 32'h0);
    chk("rst.count", 32'(instr_count), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.illegal", 32'(illegal), 32'h0);
    rst = 1;
    cyc("r.f", 0, 16'h9410); cyc("r.d", 1, 16'h0030);
    cyc("r.ex", 6, 16'h0048);
    chk("r.cnt0", 32'(instr_count), 32'h0);
    cyc("r.wb", 7, 16'h0180);
    chk("r.cnt1", 32'(instr_count), 32'h1);
    opcode = 6'b100011;
    cyc("lw.f", 0, 16'h9410); cyc("lw.d", 1, 16'h0030); cyc("lw.adr", 2, 16'h0060);
    mem_ready = 0;
    repeat (3) cyc("lw.stall", 3, 16'h3000);
    mem_ready = 1;
    cyc("lw.rd", 3, 16'h3000); cyc("lw.wb", 4, 16'h0280);
    chk("lw.cnt", 32'(instr_count), 32'h2);
    opcode = 6'b000100;
    cyc("beq.f", 0, 16'h9410); cyc("beq.d", 1, 16'h0030); cyc("beq.br", 8, 16'h4045);
    chk("beq.cnt", 32'(instr_count), 32'h3);
    opcode = 6'b000010;
    cyc("j.f", 0, 16'h9410); cyc("j.d", 1, 16'h0030); cyc("j.j", 11, 16'h8002);
    chk("j.cnt", 32'(instr_count), 32'h4);
    opcode = 6'b001000;
    cyc("addi.f", 0, 16'h9410); cyc("addi.d", 1, 16'h0030);
    cyc("addi.ex", 9, 16'h0060); cyc("addi.wb", 10, 16'h0080);
    chk("addi.cnt", 32'(instr_count), 32'h5);
    opcode = 6'b101011;
    cyc("sw.f", 0, 16'h9410); cyc("sw.d", 1, 16'h0030); cyc("sw.adr", 2, 16'h0060);
    mem_ready = 0;
    cyc("sw.stall", 5, 16'h2800);
    chk("sw.cnt_stall", 32'(instr_count), 32'h5);
    mem_ready = 1;
    cyc("sw.wr", 5, 16'h2800);
    chk("sw.cnt", 32'(instr_count), 32'h6);
    opcode = 6'b000010;
    cyc("j2.f", 0, 16'h9410); cyc("j2.d", 1, 16'h0030); cyc("j2.j", 11, 16'h8002);
    chk("cnt7", 32'(instr_count), 32'h7);
    cyc("j3.f", 0, 16'h9410); cyc("j3.d", 1, 16'h0030); cyc("j3.j", 11, 16'h8002);
    chk("cnt.sat", 32'(instr_count), 32'h7);
    mem_ready = 0;
    cyc("f.stall", 0, 16'h1010); cyc("f.stall", 0, 16'h1010);
    mem_ready = 1;
    opcode = 6'b000000;
    cyc("h.f", 0, 16'h9410); cyc("h.d", 1, 16'h0030);
    halt = 1;
    cyc("h.ex", 6, 16'h0048); cyc("h.wb", 7, 16'h0180);
    repeat (3) cyc("h.park", 0, 16'h0000);
    chk("h.busy", 32'(busy), 32'h0);
    chk("h.cnt", 32'(instr_count), 32'h7);
    halt = 0;
    opcode = 6'b101011;
    cyc("rw.f", 0, 16'h9410); cyc("rw.d", 1, 16'h0030); cyc("rw.adr", 2, 16'h0060);
    mem_ready = 0;
    cyc("rw.wr", 5, 16'h2800);
    rst = 0;
    #1;
    chk("rw.strobes", 32'(strobes), 32'h0);
    chk("rw.state", 32'(state), 32'h0);
    chk("rw.cnt", 32'(instr_count), 32'h0);
    step();
    rst = 1; mem_ready = 1;
    opcode = 6'b111111;
    cyc("il.f", 0, 16'h9410); cyc("il.d", 1, 16'h0030);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      #1;
      chk("il.state", 32'(state), 32'hc);
      chk("il.flag", 32'(illegal), 32'h1);
      chk("il.busy", 32'(busy), 32'h1);
      chk("il.strobes", 32'(strobes), 32'h0);
      step();
    end
    rst = 0;
    #1;
    chk("il.rst_state", 32'(state), 32'h0);
    chk("il.rst_flag", 32'(illegal), 32'h0);
    step();
    rst = 1; mem_ready = 1;
    cyc("post.f", 0, 16'h9410);
    chk("post.flag", 32'(illegal), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
